// File: rtl/relay_sched_pkg.sv
// Shared types and default timing for the latching-relay pulse scheduler.
package relay_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PULSE    = 2'd1,
    ST_DEADTIME = 2'd2
  } state_t;

  // 10 ms coil pulse and 1 ms all-off gap at 125 MHz.
  localparam int DEFAULT_PULSE_CYCLES    = 1250000;
  localparam int DEFAULT_DEADTIME_CYCLES = 125000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/relay_rr_arbiter.sv
// Round-robin pick among pending relays; grant is combinational, search start is registered.
// The pointer moves to the index after the granted one only when the grant is taken.
module relay_rr_arbiter #(
  parameter int NUM_RELAYS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_RELAYS-1:0]         req,
  input  logic                          advance,
  output logic                          gnt_vld,
  output logic [$clog2(NUM_RELAYS)-1:0] gnt_idx
);
  localparam int IW = $clog2(NUM_RELAYS);

  logic [IW-1:0] ptr;

  // Walk from the far end back to ptr so the closest requester wins.
  always_comb begin
    int idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = NUM_RELAYS - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_RELAYS) idx = idx - NUM_RELAYS;
      if (req[IW'(idx)]) begin
        gnt_vld = 1'b1;
        gnt_idx = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (gnt_idx == IW'(NUM_RELAYS - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end

endmodule

// File: rtl/relay_pulse_scheduler.sv
// Serialises set/reset coil pulses for latching relays: one pulse at a time, dead time after each.
// Drive starts one edge after a command on an idle block; RELAY_SKIP_REDUNDANT_EN skips pulses to a known position.
module relay_pulse_scheduler
  import relay_sched_pkg::*;
#(
  parameter int NUM_RELAYS      = 4,
  parameter int PULSE_CYCLES    = DEFAULT_PULSE_CYCLES,
  parameter int DEADTIME_CYCLES = DEFAULT_DEADTIME_CYCLES
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_en,
  input  logic [$clog2(NUM_RELAYS)-1:0] cmd_relay,
  input  logic                          cmd_dir,
  output logic [NUM_RELAYS-1:0]         relay_a,
  output logic [NUM_RELAYS-1:0]         relay_b,
  output logic                          busy,
  output logic                          done_valid,
  output logic [$clog2(NUM_RELAYS)-1:0] done_relay,
  output logic [NUM_RELAYS-1:0]         relay_pos
);
  localparam int IW = $clog2(NUM_RELAYS);
  localparam int CW = $clog2(max_int(PULSE_CYCLES, DEADTIME_CYCLES) + 1);

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [NUM_RELAYS-1:0] pending, pending_nxt;
  logic [NUM_RELAYS-1:0] pend_dir, pend_dir_nxt;
  logic [IW-1:0]         cur_relay, cur_relay_nxt;
  logic                  cur_dir, cur_dir_nxt;
  logic [NUM_RELAYS-1:0] relay_a_nxt, relay_b_nxt, relay_pos_nxt;
  logic                  done_valid_nxt, busy_nxt;
  logic [IW-1:0]         done_relay_nxt;
  logic                  gnt_vld, grant_take, skip;
  logic [IW-1:0]         gnt_idx;

`ifdef RELAY_SKIP_REDUNDANT_EN
  logic [NUM_RELAYS-1:0] pos_known, pos_known_nxt;
  assign skip = pos_known[gnt_idx] && (relay_pos[gnt_idx] == pend_dir[gnt_idx]);
`else
  assign skip = 1'b0;
`endif

  relay_rr_arbiter #(.NUM_RELAYS(NUM_RELAYS)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (pending),
    .advance (grant_take),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    pending_nxt    = pending;
    pend_dir_nxt   = pend_dir;
    cur_relay_nxt  = cur_relay;
    cur_dir_nxt    = cur_dir;
    relay_a_nxt    = '0;
    relay_b_nxt    = '0;
    done_valid_nxt = 1'b0;
    done_relay_nxt = done_relay;
    relay_pos_nxt  = relay_pos;
    grant_take     = 1'b0;
`ifdef RELAY_SKIP_REDUNDANT_EN
    pos_known_nxt  = pos_known;
`endif
    case (state)
      ST_IDLE: begin
        if (gnt_vld) begin
          grant_take           = 1'b1;
          pending_nxt[gnt_idx] = 1'b0;
          if (skip) begin
            done_valid_nxt = 1'b1;
            done_relay_nxt = gnt_idx;
          end else begin
            state_nxt            = ST_PULSE;
            cnt_nxt              = CW'(PULSE_CYCLES);
            cur_relay_nxt        = gnt_idx;
            cur_dir_nxt          = pend_dir[gnt_idx];
            relay_a_nxt[gnt_idx] = pend_dir[gnt_idx];
            relay_b_nxt[gnt_idx] = ~pend_dir[gnt_idx];
          end
        end
      end
      ST_PULSE: begin
        if (cnt == CW'(1)) begin
          state_nxt                = ST_DEADTIME;
          cnt_nxt                  = CW'(DEADTIME_CYCLES);
          done_valid_nxt           = 1'b1;
          done_relay_nxt           = cur_relay;
          relay_pos_nxt[cur_relay] = cur_dir;
`ifdef RELAY_SKIP_REDUNDANT_EN
          pos_known_nxt[cur_relay] = 1'b1;
`endif
        end else begin
          cnt_nxt     = cnt - CW'(1);
          relay_a_nxt = relay_a;
          relay_b_nxt = relay_b;
        end
      end
      ST_DEADTIME: begin
        if (cnt == CW'(1)) state_nxt = ST_IDLE;
        else               cnt_nxt   = cnt - CW'(1);
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Applied after the grant clear so a command to the granted relay queues a fresh entry.
    if (cmd_en) begin
      pending_nxt[cmd_relay]  = 1'b1;
      pend_dir_nxt[cmd_relay] = cmd_dir;
    end
    busy_nxt = (state_nxt != ST_IDLE) || (|pending_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      pending    <= '0;
      pend_dir   <= '0;
      cur_relay  <= '0;
      cur_dir    <= 1'b0;
      relay_a    <= '0;
      relay_b    <= '0;
      busy       <= 1'b0;
      done_valid <= 1'b0;
      done_relay <= '0;
      relay_pos  <= '0;
`ifdef RELAY_SKIP_REDUNDANT_EN
      pos_known  <= '0;
`endif
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      pending    <= pending_nxt;
      pend_dir   <= pend_dir_nxt;
      cur_relay  <= cur_relay_nxt;
      cur_dir    <= cur_dir_nxt;
      relay_a    <= relay_a_nxt;
      relay_b    <= relay_b_nxt;
      busy       <= busy_nxt;
      done_valid <= done_valid_nxt;
      done_relay <= done_relay_nxt;
      relay_pos  <= relay_pos_nxt;
`ifdef RELAY_SKIP_REDUNDANT_EN
      pos_known  <= pos_known_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_relay_pulse_scheduler.sv
// Bench for relay_pulse_scheduler: vector table, directed corner sequences and random traffic
// checked against a timeline model of pulses, dead time and round-robin service.
module tb_relay_pulse_scheduler;
  localparam int N = 4;
  localparam int P = 8;
  localparam int D = 4;
  localparam int ROWS = P + D + 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_en;
  logic [1:0] cmd_relay;
  logic       cmd_dir;
  logic [3:0] relay_a, relay_b, relay_pos;
  logic       busy, done_valid;
  logic [1:0] done_relay;

  relay_pulse_scheduler #(.NUM_RELAYS(N), .PULSE_CYCLES(P), .DEADTIME_CYCLES(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_en     (cmd_en),
    .cmd_relay  (cmd_relay),
    .cmd_dir    (cmd_dir),
    .relay_a    (relay_a),
    .relay_b    (relay_b),
    .busy       (busy),
    .done_valid (done_valid),
    .done_relay (done_relay),
    .relay_pos  (relay_pos)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Timeline model: a grant at edge t drives edges t..t+P-1, completes at t+P,
  // and the next grant is possible at edge t+P+D+1.
  bit m_pend[N];
  bit m_pdir[N];
  bit m_pos[N];
  bit m_known[N];
  int m_ptr, m_edge, m_can, m_start, m_rel, m_dr;
  bit m_dir, m_dv;

  int cyc;
  int dv_seen;
  logic [7:0] prev_ab;
  int rises[$];
  int rise_cyc[$];
  int fall_cyc[$];

  typedef struct {
    bit         en;
    int         rel;
    bit         dir;
    logic [3:0] a;
    logic [3:0] b;
    logic       dv;
    logic       bsy;
  } vec_t;
  vec_t tbl[ROWS];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 0; m_pdir[i] = 0; m_pos[i] = 0; m_known[i] = 0;
    end
    m_ptr = 0; m_edge = 0; m_can = 0; m_start = -1000; m_rel = 0; m_dr = 0;
    m_dir = 0; m_dv = 0;
    prev_ab = '0;
  endtask

  task automatic model_edge(input bit en, input int rel, input bit dir);
    int g;
    bit skip;
    g    = -1;
    skip = 0;
    m_dv = 0;
    if (m_edge == m_start + P) begin
      m_pos[m_rel] = m_dir;
      m_known[m_rel] = 1;
      m_dv = 1;
      m_dr = m_rel;
    end
    if (m_edge >= m_can) begin
      for (int k = 0; k < N; k++)
        if (g < 0 && m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      if (g >= 0) begin
        m_pend[g] = 0;
        m_ptr = (g + 1) % N;
`ifdef RELAY_SKIP_REDUNDANT_EN
        skip = m_known[g] && (m_pos[g] == m_pdir[g]);
`endif
        if (skip) begin
          m_dv = 1; m_dr = g; m_can = m_edge + 1;
        end else begin
          m_start = m_edge; m_rel = g; m_dir = m_pdir[g]; m_can = m_edge + P + D + 1;
        end
      end
    end
    if (en) begin
      m_pend[rel] = 1;
      m_pdir[rel] = dir;
    end
  endtask

  task automatic compare_model();
    logic [3:0] ea, eb, epos;
    logic       ebusy;
    ea = '0; eb = '0; epos = '0;
    if (m_edge >= m_start && m_edge < m_start + P) begin
      if (m_dir) ea[m_rel] = 1'b1;
      else       eb[m_rel] = 1'b1;
    end
    ebusy = (m_edge < m_can - 1);
    for (int i = 0; i < N; i++) begin
      epos[i] = m_pos[i];
      if (m_pend[i]) ebusy = 1'b1;
    end
    check("model_outputs", {relay_a, relay_b, done_valid, done_relay, relay_pos, busy},
          {ea, eb, m_dv, 2'(m_dr), epos, ebusy});
    check("one_hot_drive", 64'($countones({relay_a, relay_b}) <= 1), 64'(1));
    m_edge++;
  endtask

  task automatic tick(input bit en, input int rel, input bit dir);
    cmd_en = en; cmd_relay = 2'(rel); cmd_dir = dir;
    @(posedge clk);
    model_edge(en, rel, dir);
    #1;
    cmd_en = 1'b0;
    compare_model();
    for (int i = 0; i < N; i++) begin
      if (relay_a[i] && !prev_ab[i + 4]) rises.push_back(i + 4);
      if (relay_b[i] && !prev_ab[i])     rises.push_back(i);
    end
    if ((|{relay_a, relay_b}) && !(|prev_ab)) rise_cyc.push_back(cyc);
    if (!(|{relay_a, relay_b}) && (|prev_ab)) fall_cyc.push_back(cyc);
    if (done_valid) dv_seen++;
    prev_ab = {relay_a, relay_b};
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0);
  endtask

  initial begin
    int dv0, pulses0;
    cyc = 0; dv_seen = 0;
    rst_n = 1'b0; cmd_en = 1'b0; cmd_relay = '0; cmd_dir = 1'b0;
    model_reset();

    for (int i = 0; i < ROWS; i++) tbl[i] = '{0, 0, 0, 4'h0, 4'h0, 1'b0, 1'b1};
    tbl[0].en = 1; tbl[0].rel = 2; tbl[0].dir = 1;
    for (int i = 1; i <= P; i++) tbl[i].a = 4'b0100;
    tbl[P + 1].dv = 1'b1;
    tbl[P + D + 1].bsy = 1'b0;
    tbl[P + D + 2].bsy = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {relay_a, relay_b, done_valid, done_relay, relay_pos, busy}, 64'd0);
    rst_n = 1'b1;

    // Single command to relay 2, set direction.
    for (int i = 0; i < ROWS; i++) begin
      tick(tbl[i].en, tbl[i].rel, tbl[i].dir);
      check("single_cmd_row", {relay_a, relay_b, done_valid, busy},
            {tbl[i].a, tbl[i].b, tbl[i].dv, tbl[i].bsy});
    end
    check("single_done_relay", 64'(done_relay), 64'd2);
    check("single_relay_pos", 64'(relay_pos), 64'b0100);

    // Backlog: relay 3 pulses, then 3, 0, 1 queue up and are served 0, 1, 3.
    rises.delete(); rise_cyc.delete(); fall_cyc.delete();
    tick(1, 3, 1);
    tick(1, 3, 0);
    tick(1, 0, 1);
    tick(1, 1, 0);
    idle(70);
    check("backlog_pulse_count", 64'(rises.size()), 64'd4);
    if (rises.size() == 4) begin
      check("backlog_order0", 64'(rises[0]), 64'd7);
      check("backlog_order1", 64'(rises[1]), 64'd4);
      check("backlog_order2", 64'(rises[2]), 64'd1);
      check("backlog_order3", 64'(rises[3]), 64'd3);
    end
    for (int k = 0; k < rise_cyc.size() && k < fall_cyc.size(); k++)
      check("pulse_len", 64'(fall_cyc[k] - rise_cyc[k]), 64'(P));
    for (int k = 0; k + 1 < rise_cyc.size() && k < fall_cyc.size(); k++)
      check("deadtime_gap", 64'((rise_cyc[k + 1] - fall_cyc[k]) >= D &&
                                (rise_cyc[k + 1] - fall_cyc[k]) <= D + 1), 64'd1);

    // Overwrite while pending: only the latest direction pulses.
    rises.delete();
    tick(1, 2, 1);
    tick(1, 1, 1);
    tick(1, 1, 0);
    idle(45);
    check("overwrite_pulse_count", 64'(rises.size()), 64'd2);
    if (rises.size() == 2) check("overwrite_on_b1", 64'(rises[1]), 64'd1);

    // Reset mid-PULSE: outputs drop before the next edge, no completion afterwards.
    tick(1, 1, 0);
    idle(3);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async_drive", {relay_a, relay_b, done_valid, busy}, 64'd0);
    check("reset_async_state", {done_relay, relay_pos}, 64'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    dv0 = dv_seen;
    idle(12);
    check("no_done_after_reset", 64'(dv_seen - dv0), 64'd0);

    // Same direction twice on relay 0.
    rises.delete();
    dv0 = dv_seen;
    tick(1, 0, 1);
    idle(20);
    tick(1, 0, 1);
    idle(20);
    pulses0 = rises.size();
`ifdef RELAY_SKIP_REDUNDANT_EN
    check("repeat_set_pulses", 64'(pulses0), 64'd1);
`else
    check("repeat_set_pulses", 64'(pulses0), 64'd2);
`endif
    check("repeat_set_dones", 64'(dv_seen - dv0), 64'd2);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++)
      tick($urandom_range(0, 5) == 0, int'($urandom_range(0, N - 1)), bit'($urandom_range(0, 1)));
    idle(80);
    check("drain_idle", {busy, relay_a, relay_b}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
